// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: registered valid/ready pipeline stage with a two-entry skid buffer,
// synchronous flush and occupancy count.
module pipe_skid_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    localparam logic [1:0] EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2;
    logic [WIDTH-1:0] main_q, skid_q, main_n, skid_n;
    logic [1:0]       cnt_n;
    logic             in_fire, out_fire;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_q;
    always_comb begin
        cnt_n  = count;
        main_n = main_q;
        skid_n = skid_q;
        case (count)
            EMPTY: if (in_fire) begin
                main_n = in_data;
                cnt_n  = BUSY;
            end
            BUSY: if (in_fire && out_fire) begin
                main_n = in_data;
            end else if (in_fire) begin
                skid_n = in_data;
                cnt_n  = FULL;
            end else if (out_fire) begin
                cnt_n  = EMPTY;
            end
            FULL: if (out_fire) begin
                main_n = skid_q;
                cnt_n  = BUSY;
            end
            default: cnt_n = EMPTY;
        endcase
    end
    // Handshake flags are registered from the next occupancy so stalls never ripple combinationally.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            count     <= EMPTY;
            main_q    <= RESET_VAL;
            skid_q    <= RESET_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            count     <= cnt_n;
            main_q    <= main_n;
            skid_q    <= skid_n;
            out_valid <= (cnt_n != EMPTY);
            in_ready  <= (cnt_n != FULL);
        end
    end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed vector table plus randomised run against a queue-based scoreboard.
module tb_pipe_skid_reg;
    localparam logic [31:0] RV = 32'h0000_BEEF;
    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  count;
    int          total = 0, bad = 0;
    logic [31:0] sb[$];
    logic [31:0] delivered[$];
    logic [31:0] m_main = RV;
    logic        last_acc;

    typedef struct {
        logic        r, f, iv;
        logic [31:0] d;
        logic        ordy;
        logic [1:0]  e_cnt;
        logic        e_ov, e_ir;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[$];

    pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input logic r, f, iv, input logic [31:0] d, input logic ordy,
                     input logic [1:0] ec, input logic eov, eir, input logic [31:0] ed);
        vec_t t;
        t.r = r; t.f = f; t.iv = iv; t.d = d; t.ordy = ordy;
        t.e_cnt = ec; t.e_ov = eov; t.e_ir = eir; t.e_data = ed;
        vecs.push_back(t);
    endtask

    // One clock: drive inputs, advance the reference model at the edge, compare just after it.
    task automatic cyc(input logic r, f, iv, input logic [31:0] d, input logic ordy);
        logic of, inf;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        last_acc = 1'b0;
        if (!r) begin
            sb.delete();
            m_main = RV;
        end else if (f) begin
            if (sb.size() > 0 && ordy) delivered.push_back(sb[0]);
            sb.delete();
            m_main = RV;
        end else begin
            of  = (sb.size() > 0) && ordy;
            inf = iv && (sb.size() < 2);
            if (of) delivered.push_back(sb.pop_front());
            if (inf) sb.push_back(d);
            if (sb.size() > 0) m_main = sb[0];
            last_acc = inf;
        end
        #1;
        chk("count", 32'(count), 32'(sb.size()));
        chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        chk("out_data", out_data, m_main);
    endtask

    initial begin
        logic [31:0] exp_order[$];
        logic        iv, hold;
        logic [31:0] d;
        // reset with a beat offered
        v(0,0,1,32'hDEAD,0, 0,0,1,RV);
        v(0,0,1,32'hDEAD,0, 0,0,1,RV);
        // streaming 1..8
        v(1,0,1,32'h1,1, 1,1,1,32'h1);
        for (int i = 2; i <= 8; i++) v(1,0,1,32'(i),1, 1,1,1,32'(i));
        v(1,0,0,32'h0,1, 0,0,1,32'h8);
        // skid absorption and release
        v(1,0,1,32'hA,1, 1,1,1,32'hA);
        v(1,0,1,32'hB,0, 2,1,0,32'hA);
        v(1,0,1,32'hC,0, 2,1,0,32'hA);
        v(1,0,1,32'hC,0, 2,1,0,32'hA);
        v(1,0,1,32'hC,1, 1,1,1,32'hB);
        v(1,0,1,32'hC,1, 1,1,1,32'hC);
        v(1,0,0,32'h0,1, 0,0,1,32'hC);
        // flush while full with a beat offered
        v(1,0,1,32'h11,0, 1,1,1,32'h11);
        v(1,0,1,32'h22,0, 2,1,0,32'h11);
        v(1,1,1,32'h33,0, 0,0,1,RV);
        v(1,0,0,32'h0,1, 0,0,1,RV);
        // reset while full
        v(1,0,1,32'h66,0, 1,1,1,32'h66);
        v(1,0,1,32'h77,0, 2,1,0,32'h66);
        v(0,0,1,32'h88,0, 0,0,1,RV);
        v(1,0,1,32'h55,1, 1,1,1,32'h55);
        v(1,0,0,32'h0,1, 0,0,1,32'h55);

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
        end
        for (int i = 1; i <= 8; i++) exp_order.push_back(32'(i));
        exp_order.push_back(32'hA);
        exp_order.push_back(32'hB);
        exp_order.push_back(32'hC);
        exp_order.push_back(32'h55);
        chk("delivered_len", 32'(delivered.size()), 32'(exp_order.size()));
        foreach (exp_order[i])
            chk($sformatf("delivered%0d", i), (i < delivered.size()) ? delivered[i] : 32'hX, exp_order[i]);

        // randomised traffic; a refused beat is held upstream unchanged
        hold = 1'b0;
        d = '0;
        for (int n = 0; n < 10000; n++) begin
            logic f;
            f = ($urandom_range(0, 99) < 5);
            if (!hold) begin
                iv = $urandom_range(0, 1);
                d  = $urandom;
            end
            cyc(1, f, iv, d, $urandom_range(0, 1));
            hold = iv && !last_acc && !f;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
